icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's instruction port. Fetch hits return in one cycle. On a miss the cache acts as the initiator on the memory controller's icache flag/ok handshake: it requests the aligned word, fills the line, and forwards the word to fetch. A branch-misprediction clear aborts any outstanding miss. `readyIn` low freezes the whole block.

---
 rtl/icache.sv | 145 ++++++++++++++
 tb/tb_icache.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache
//
// Purpose: serves fetch requests from a direct-mapped array of 2^INDEX_WIDTH
// one-word lines. Hits answer one cycle after the request; misses fetch the
// aligned word from the memory controller, fill the line and forward it.
//
// Ports:
//   clockIn, resetIn        clock, synchronous active-high reset
//   readyIn                 global enable; no state changes while low
//   clearIn                 misprediction flush, aborts an outstanding miss
//   ifetchFlag, ifetchAddr  fetch request and byte address
//   instrOk, instrOut       one-cycle response pulse and instruction word
//   memFlag, memAddr        fill request to the memory controller
//   memOk, memData          fill completion pulse and data

module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        clearIn,
    input  logic        ifetchFlag,
    input  logic [31:0] ifetchAddr,
    output logic        instrOk,
    output logic [31:0] instrOut,
    output logic        memFlag,
    output logic [31:0] memAddr,
    input  logic        memOk,
    input  logic [31:0] memData
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    logic [31:0] r_req_addr;
    logic        r_instr_ok;
    logic [31:0] r_instr_out;

    logic [31:0] w_next_req_addr;
    logic        w_next_instr_ok;
    logic [31:0] w_next_instr_out;

    logic [INDEX_WIDTH-1:0] w_fetch_index;
    logic [TAG_W-1:0]       w_fetch_tag;
    logic [INDEX_WIDTH-1:0] w_fill_index;
    logic [TAG_W-1:0]       w_fill_tag;
    logic                   w_hit;
    logic                   w_fill;
    logic                   w_unused_ok;

    assign w_fetch_index = ifetchAddr[1+INDEX_WIDTH:2];
    assign w_fetch_tag   = ifetchAddr[31:2+INDEX_WIDTH];
    assign w_fill_index  = r_req_addr[1+INDEX_WIDTH:2];
    assign w_fill_tag    = r_req_addr[31:2+INDEX_WIDTH];
    assign w_hit         = r_valid[w_fetch_index] && (r_tag[w_fetch_index] == w_fetch_tag);
    assign w_unused_ok   = ^ifetchAddr[1:0];

    // Combinational so the request is already withdrawn in the memOk cycle;
    // the controller re-samples the flag the cycle after raising ok.
    assign memFlag  = (r_state == WAIT) & ~memOk;
    assign memAddr  = r_req_addr;
    assign instrOk  = r_instr_ok;
    assign instrOut = r_instr_out;

    always_comb begin
        w_next_state     = r_state;
        w_next_req_addr  = r_req_addr;
        w_next_instr_ok  = r_instr_ok;
        w_next_instr_out = r_instr_out;
        w_fill           = 1'b0;
        if (readyIn) begin
            if (clearIn) begin
                w_next_state    = IDLE;
                w_next_instr_ok = 1'b0;
                // Data returned alongside a flush is still correct, so keep it.
                w_fill          = (r_state == WAIT) && memOk;
            end else begin
                case (r_state)
                    IDLE: begin
                        w_next_instr_ok = 1'b0;
                        if (ifetchFlag) begin
                            if (w_hit) begin
                                w_next_instr_ok  = 1'b1;
                                w_next_instr_out = r_data[w_fetch_index];
                            end else begin
                                w_next_req_addr = {ifetchAddr[31:2], 2'b00};
                                w_next_state    = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        w_next_instr_ok = 1'b0;
                        if (memOk) begin
                            w_fill           = 1'b1;
                            w_next_instr_ok  = 1'b1;
                            w_next_instr_out = memData;
                            w_next_state     = IDLE;
                        end
                    end
                    default: w_next_state = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_req_addr  <= '0;
            r_instr_ok  <= 1'b0;
            r_instr_out <= '0;
        end else begin
            r_state     <= w_next_state;
            r_req_addr  <= w_next_req_addr;
            r_instr_ok  <= w_next_instr_ok;
            r_instr_out <= w_next_instr_out;
            if (w_fill) begin
                r_valid[w_fill_index] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits guard it.
    always_ff @(posedge clockIn) begin
        if (!resetIn && w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= memData;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache

module tb_icache;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        readyIn;
    logic        clearIn;
    logic        ifetchFlag;
    logic [31:0] ifetchAddr;
    logic        instrOk;
    logic [31:0] instrOut;
    logic        memFlag;
    logic [31:0] memAddr;
    logic        memOk;
    logic [31:0] memData;

    int n_cmp = 0;
    int n_err = 0;

    icache #(.INDEX_WIDTH(6)) dut (
        .clockIn   (clockIn),
        .resetIn   (resetIn),
        .readyIn   (readyIn),
        .clearIn   (clearIn),
        .ifetchFlag(ifetchFlag),
        .ifetchAddr(ifetchAddr),
        .instrOk   (instrOk),
        .instrOut  (instrOut),
        .memFlag   (memFlag),
        .memAddr   (memAddr),
        .memOk     (memOk),
        .memData   (memData)
    );

    always #5 clockIn = ~clockIn;

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full miss: request, wait lat cycles with memFlag up, return data.
    task automatic do_miss(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input int lat);
        ifetchFlag = 1'b1;
        ifetchAddr = addr;
        tick();
        ifetchFlag = 1'b0;
        chk({tag, "_flag"}, {31'd0, memFlag}, 32'd1);
        chk({tag, "_addr"}, memAddr, {addr[31:2], 2'b00});
        chk({tag, "_ok0"}, {31'd0, instrOk}, 32'd0);
        for (int i = 1; i < lat; i++) tick();
        chk({tag, "_flag_hold"}, {31'd0, memFlag}, 32'd1);
        memOk   = 1'b1;
        memData = data;
        #1;
        chk({tag, "_flag_okcyc"}, {31'd0, memFlag}, 32'd0);
        tick();
        memOk = 1'b0;
        chk({tag, "_ok"}, {31'd0, instrOk}, 32'd1);
        chk({tag, "_data"}, instrOut, data);
        tick();
        chk({tag, "_ok_drop"}, {31'd0, instrOk}, 32'd0);
    endtask

    task automatic do_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
        ifetchFlag = 1'b1;
        ifetchAddr = addr;
        tick();
        ifetchFlag = 1'b0;
        chk({tag, "_ok"}, {31'd0, instrOk}, 32'd1);
        chk({tag, "_data"}, instrOut, data);
        chk({tag, "_noflag"}, {31'd0, memFlag}, 32'd0);
        tick();
        chk({tag, "_ok_drop"}, {31'd0, instrOk}, 32'd0);
    endtask

    initial begin
        resetIn    = 1'b1;
        readyIn    = 1'b1;
        clearIn    = 1'b0;
        ifetchFlag = 1'b0;
        ifetchAddr = '0;
        memOk      = 1'b0;
        memData    = '0;
        tick();
        tick();
        resetIn = 1'b0;
        chk("rst_ok", {31'd0, instrOk}, 32'd0);
        chk("rst_out", instrOut, 32'd0);
        chk("rst_flag", {31'd0, memFlag}, 32'd0);
        chk("rst_addr", memAddr, 32'd0);

        // Cold miss then hit with unaligned address, then back-to-back hits.
        do_miss("cold", 32'h0000_0004, 32'h0000_0013, 5);
        do_hit("hit6", 32'h0000_0006, 32'h0000_0013);
        ifetchFlag = 1'b1;
        ifetchAddr = 32'h0000_0004;
        tick();
        chk("b2b_ok1", {31'd0, instrOk}, 32'd1);
        tick();
        chk("b2b_ok2", {31'd0, instrOk}, 32'd1);
        chk("b2b_data", instrOut, 32'h0000_0013);
        ifetchFlag = 1'b0;
        tick();
        chk("b2b_drop", {31'd0, instrOk}, 32'd0);

        // Conflict on index 0.
        do_miss("fill0", 32'h0000_0000, 32'h0000_00A0, 2);
        do_miss("conf100", 32'h0000_0100, 32'h0000_00B0, 3);
        do_miss("refill0", 32'h0000_0000, 32'h0000_00A1, 1);
        do_hit("hit0", 32'h0000_0000, 32'h0000_00A1);

        // Clear two cycles into a miss.
        ifetchFlag = 1'b1;
        ifetchAddr = 32'h0000_0200;
        tick();
        ifetchFlag = 1'b0;
        chk("clr_flag_up", {31'd0, memFlag}, 32'd1);
        tick();
        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
        chk("clr_flag_drop", {31'd0, memFlag}, 32'd0);
        chk("clr_ok0", {31'd0, instrOk}, 32'd0);
        tick();
        tick();
        chk("clr_no_ok", {31'd0, instrOk}, 32'd0);
        do_miss("clr_remiss", 32'h0000_0200, 32'h0000_0055, 2);

        // memOk coincident with clear: filled but no response.
        ifetchFlag = 1'b1;
        ifetchAddr = 32'h0000_0300;
        tick();
        ifetchFlag = 1'b0;
        memOk   = 1'b1;
        memData = 32'hDEAD_BEEF;
        clearIn = 1'b1;
        tick();
        memOk   = 1'b0;
        clearIn = 1'b0;
        chk("okclr_no_ok", {31'd0, instrOk}, 32'd0);
        chk("okclr_flag", {31'd0, memFlag}, 32'd0);
        do_hit("okclr_hit", 32'h0000_0300, 32'hDEAD_BEEF);

        // Stall across the memOk cycle.
        ifetchFlag = 1'b1;
        ifetchAddr = 32'h0000_0400;
        tick();
        ifetchFlag = 1'b0;
        memOk   = 1'b1;
        memData = 32'h0000_0077;
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mem_ok", {31'd0, instrOk}, 32'd0);
            chk("stall_mem_flag", {31'd0, memFlag}, 32'd0);
        end
        readyIn = 1'b1;
        tick();
        memOk = 1'b0;
        chk("stall_fill_ok", {31'd0, instrOk}, 32'd1);
        chk("stall_fill_data", instrOut, 32'h0000_0077);
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pulse_hold", {31'd0, instrOk}, 32'd1);
        end
        readyIn = 1'b1;
        tick();
        chk("stall_pulse_drop", {31'd0, instrOk}, 32'd0);

        // Stall across a hit pulse.
        ifetchFlag = 1'b1;
        ifetchAddr = 32'h0000_0400;
        tick();
        ifetchFlag = 1'b0;
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hit_ok", {31'd0, instrOk}, 32'd1);
            chk("stall_hit_data", instrOut, 32'h0000_0077);
        end
        readyIn = 1'b1;
        tick();
        chk("stall_hit_drop", {31'd0, instrOk}, 32'd0);

        // Reset during WAIT, then previously filled lines miss.
        ifetchFlag = 1'b1;
        ifetchAddr = 32'h0000_0500;
        tick();
        ifetchFlag = 1'b0;
        chk("rstw_flag_up", {31'd0, memFlag}, 32'd1);
        resetIn = 1'b1;
        tick();
        resetIn = 1'b0;
        chk("rstw_flag", {31'd0, memFlag}, 32'd0);
        chk("rstw_ok", {31'd0, instrOk}, 32'd0);
        chk("rstw_addr", memAddr, 32'd0);
        do_miss("rstw_inv4", 32'h0000_0004, 32'h0000_0014, 1);
        do_miss("rstw_inv300", 32'h0000_0300, 32'h0000_0030, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
